// File: rtl/pkt_tuple_extractor_pkg.sv
// Shared constants and types for the Ethernet/IPv4 5-tuple extractor.
package pkt_pkg;

   localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
   localparam logic [7:0]  IPV4_VER_IHL    = 8'h45;
   localparam logic [7:0]  PROTO_TCP       = 8'd6;
   localparam logic [7:0]  PROTO_UDP       = 8'd17;
   localparam logic [3:0]  TUPLE_LAST_WORD = 4'd9;

   // Word indices within the frame where header fields live
   localparam logic [3:0]  W_ETHERTYPE = 4'd3;
   localparam logic [3:0]  W_PROTO     = 4'd5;
   localparam logic [3:0]  W_SRC_HI    = 4'd6;
   localparam logic [3:0]  W_SRC_DST   = 4'd7;
   localparam logic [3:0]  W_DST_SPORT = 4'd8;

   typedef enum logic [0:0] {PARSE, DRAIN} ext_state_t;

   typedef struct packed {
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [7:0]  proto;
      logic [15:0] sport;
      logic [15:0] dport;
   } five_tuple_t;

   function automatic logic has_ports(input logic [7:0] proto);
      return (proto == PROTO_TCP) || (proto == PROTO_UDP);
   endfunction

endpackage

// File: rtl/pkt_tuple_extractor.sv
// Parses an Ethernet/IPv4 word stream and presents the 5-tuple through a
// one-entry valid/ready output register; skipped frames are counted.
module pkt_tuple_extractor
   import pkt_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic [71:0]      ip_pro,
   output logic [15:0]      src_port,
   output logic [15:0]      dest_port,
   output logic             tup_valid,
   input  logic             tup_ready,
   output logic [CNT_W-1:0] frames_ok,
   output logic [CNT_W-1:0] frames_drop
);

   ext_state_t  state, state_nxt;
   logic [3:0]  word_cnt, word_cnt_nxt;
   logic        xfer, hdr_ok, load_tup, drop_evt;
   logic [7:0]  cap_proto;
   logic [31:0] cap_src, cap_dst;
   logic [15:0] cap_sport;
   five_tuple_t tup_q, tup_nxt;

   // Only w9 can stall, and only when it would overwrite an unconsumed tuple
   assign s_ready = !(state == PARSE && word_cnt == TUPLE_LAST_WORD && tup_valid && !tup_ready);
   assign xfer    = s_valid && s_ready;
   assign hdr_ok  = (s_data[31:16] == ETHERTYPE_IPV4) && (s_data[15:8] == IPV4_VER_IHL);

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt    = state;
      word_cnt_nxt = word_cnt;
      load_tup     = 1'b0;
      drop_evt     = 1'b0;
      if (xfer) begin
         case (state)
            PARSE: begin
               if (word_cnt == W_ETHERTYPE && !hdr_ok) begin
                  drop_evt     = 1'b1;
                  word_cnt_nxt = '0;
                  state_nxt    = s_last ? PARSE : DRAIN;
               end else if (word_cnt == TUPLE_LAST_WORD) begin
                  load_tup     = 1'b1;
                  word_cnt_nxt = '0;
                  state_nxt    = s_last ? PARSE : DRAIN;
               end else if (s_last) begin
                  drop_evt     = 1'b1;
                  word_cnt_nxt = '0;
               end else begin
                  word_cnt_nxt = word_cnt + 4'd1;
               end
            end
            DRAIN: begin
               if (s_last) begin
                  state_nxt    = PARSE;
                  word_cnt_nxt = '0;
               end
            end
            default: state_nxt = PARSE;
         endcase
      end
   end

   always_comb begin
      tup_nxt.src_ip = cap_src;
      tup_nxt.dst_ip = cap_dst;
      tup_nxt.proto  = cap_proto;
      tup_nxt.sport  = has_ports(cap_proto) ? cap_sport      : 16'd0;
      tup_nxt.dport  = has_ports(cap_proto) ? s_data[31:16]  : 16'd0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= PARSE;
         word_cnt <= '0;
      end else begin
         state    <= state_nxt;
         word_cnt <= word_cnt_nxt;
      end
   end

   // NOTE: header capture registers carry no reset; they are always rewritten before use.
   always_ff @(posedge clk) begin
      if (xfer && state == PARSE) begin
         case (word_cnt)
            W_PROTO:     cap_proto <= s_data[7:0];
            W_SRC_HI:    cap_src[31:16] <= s_data[15:0];
            W_SRC_DST: begin
               cap_src[15:0]  <= s_data[31:16];
               cap_dst[31:16] <= s_data[15:0];
            end
            W_DST_SPORT: begin
               cap_dst[15:0] <= s_data[31:16];
               cap_sport     <= s_data[15:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tup_valid <= 1'b0;
         tup_q     <= '0;
      end else if (load_tup) begin
         tup_valid <= 1'b1;
         tup_q     <= tup_nxt;
      end else if (tup_ready) begin
         tup_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frames_ok   <= '0;
         frames_drop <= '0;
      end else begin
         if (load_tup) frames_ok   <= frames_ok + 1'b1;
         if (drop_evt) frames_drop <= frames_drop + 1'b1;
      end
   end

   assign ip_pro    = {tup_q.src_ip, tup_q.dst_ip, tup_q.proto};
   assign src_port  = tup_q.sport;
   assign dest_port = tup_q.dport;

endmodule
